// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch slice: datapath/ROM widths, the
// default halt instruction, the fetch-state encoding and a saturating counter step.
package mips_pkg;

   localparam int XLEN   = 32;
   localparam int ROM_AW = 10;

   localparam logic [XLEN-1:0] HALT_INSTR_DEFAULT = 32'h0000_000C;

   typedef enum logic [0:0] {
      FETCH_RUN    = 1'b0,
      FETCH_HALTED = 1'b1
   } fetch_state_e;

   function automatic logic [XLEN-1:0] sat_inc(input logic [XLEN-1:0] v);
      logic [XLEN-1:0] r;
      if (v == 32'hFFFF_FFFF) begin
         r = v;
      end else begin
         r = v + 32'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a fetched instruction, inserts a bubble by
// clearing valid while keeping the last pc/instr, otherwise holds.
module if_id_reg
   import mips_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            bubble,
   input  logic [XLEN-1:0] pc_in,
   input  logic [XLEN-1:0] instr_in,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_instr,
   output logic            if_valid
);

   logic [XLEN-1:0] pc_d, pc_q;
   logic [XLEN-1:0] instr_d, instr_q;
   logic            valid_d, valid_q;

   // Load has priority; a bubble only drops valid so pc/instr stay stable for debug.
   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      if (load) begin
         pc_d    = pc_in;
         instr_d = instr_in;
         valid_d = 1'b1;
      end else if (bubble) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q    <= 32'h0000_0000;
         instr_q <= 32'h0000_0000;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   assign if_pc    = pc_q;
   assign if_instr = instr_q;
   assign if_valid = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC sequencing with stall/redirect, RUN/HALTED
// fetch FSM, saturating fetch counter and the IF/ID output register.
module if_stage
   import mips_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter logic [XLEN-1:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              redirect,
   input  logic [XLEN-1:0]   redirect_pc,
   output logic [ROM_AW-1:0] rom_addr,
   output logic              rom_sel,
   input  logic [XLEN-1:0]   rom_data,
   output logic [XLEN-1:0]   if_pc,
   output logic [XLEN-1:0]   if_instr,
   output logic              if_valid,
   output logic              halted,
   output logic [XLEN-1:0]   fetch_count
);

   fetch_state_e    state_d, state_q;
   logic [XLEN-1:0] pc_d, pc_q;
   logic [XLEN-1:0] count_d, count_q;
   logic            halted_d, halted_q;
   logic            accept_s;
   logic            bubble_s;

   // Redirect beats stall; in HALTED only the bubble on a non-stall cycle remains.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      count_d  = count_q;
      accept_s = 1'b0;
      bubble_s = 1'b0;
      case (state_q)
         FETCH_RUN: begin
            if (redirect) begin
               pc_d     = redirect_pc & 32'hFFFF_FFFC;
               bubble_s = 1'b1;
            end else if (!stall) begin
               accept_s = 1'b1;
               pc_d     = pc_q + 32'd4;
               count_d  = sat_inc(count_q);
               if (rom_data == HALT_INSTR) begin
                  state_d = FETCH_HALTED;
               end else begin
                  state_d = FETCH_RUN;
               end
            end else begin
               pc_d = pc_q;
            end
         end
         FETCH_HALTED: begin
            bubble_s = !stall;
         end
         default: begin
            state_d = FETCH_RUN;
         end
      endcase
      halted_d = (state_d == FETCH_HALTED);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= FETCH_RUN;
         pc_q     <= RESET_PC & 32'hFFFF_FFFC;
         count_q  <= 32'h0000_0000;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         count_q  <= count_d;
         halted_q <= halted_d;
      end
   end

   if_id_reg u_if_id_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept_s),
      .bubble   (bubble_s),
      .pc_in    (pc_q),
      .instr_in (rom_data),
      .if_pc    (if_pc),
      .if_instr (if_instr),
      .if_valid (if_valid)
   );

   assign rom_addr    = pc_q[ROM_AW+1:2];
   assign rom_sel     = (state_q == FETCH_RUN) && rst_n;
   assign halted      = halted_q;
   assign fetch_count = count_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage with a behavioural 1K-word ROM.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [9:0]  rom_addr;
   logic        rom_sel;
   logic [31:0] rom_data;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_valid;
   logic        halted;
   logic [31:0] fetch_count;

   logic [31:0] rom [0:1023];
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign rom_data = rom_sel ? rom[rom_addr] : 32'h0000_0000;

   if_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .rom_addr    (rom_addr),
      .rom_sel     (rom_sel),
      .rom_data    (rom_data),
      .if_pc       (if_pc),
      .if_instr    (if_instr),
      .if_valid    (if_valid),
      .halted      (halted),
      .fetch_count (fetch_count)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0F00;
      step();
      step();
      if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", if_valid); end checks++;
      if (if_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", if_instr); end checks++;
      if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", if_pc); end checks++;
      if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0b want 0", halted); end checks++;
      if (fetch_count !== 32'h0) begin errors++; $display("FAIL reset_count: got %h want 0", fetch_count); end checks++;
      if (rom_addr !== 10'h0) begin errors++; $display("FAIL reset_rom_addr: got %h want 0", rom_addr); end checks++;
      if (rom_sel !== 1'b0) begin errors++; $display("FAIL reset_rom_sel_low: got %0b want 0", rom_sel); end checks++;
      rst_n = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      #1;
      if (rom_sel !== 1'b1) begin errors++; $display("FAIL reset_rom_sel_high: got %0b want 1", rom_sel); end checks++;
   endtask

   task automatic test_sequential();
      logic [31:0] exp_w [4];
      exp_w[0] = 32'h11; exp_w[1] = 32'h22; exp_w[2] = 32'h33; exp_w[3] = 32'h44;
      for (int i = 0; i < 4; i++) begin
         step();
         if (if_instr !== exp_w[i]) begin errors++; $display("FAIL seq_instr[%0d]: got %h want %h", i, if_instr, exp_w[i]); end checks++;
         if (if_pc !== 32'(i * 4)) begin errors++; $display("FAIL seq_pc[%0d]: got %h want %h", i, if_pc, 32'(i * 4)); end checks++;
         if (if_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d]: got %0b want 1", i, if_valid); end checks++;
         if (fetch_count !== 32'(i + 1)) begin errors++; $display("FAIL seq_count[%0d]: got %0d want %0d", i, fetch_count, i + 1); end checks++;
      end
      if (rom_addr !== 10'd4) begin errors++; $display("FAIL seq_rom_addr: got %h want 4", rom_addr); end checks++;
   endtask

   task automatic test_stall();
      do_reset();
      step();
      step();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         if (if_instr !== 32'h22) begin errors++; $display("FAIL stall_instr[%0d]: got %h want 22", i, if_instr); end checks++;
         if (if_pc !== 32'h4) begin errors++; $display("FAIL stall_pc[%0d]: got %h want 4", i, if_pc); end checks++;
         if (rom_addr !== 10'd2) begin errors++; $display("FAIL stall_rom_addr[%0d]: got %h want 2", i, rom_addr); end checks++;
         if (fetch_count !== 32'd2) begin errors++; $display("FAIL stall_count[%0d]: got %0d want 2", i, fetch_count); end checks++;
         if (if_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %0b want 1", i, if_valid); end checks++;
      end
      stall = 1'b0;
      step();
      if (if_instr !== 32'h33) begin errors++; $display("FAIL stall_resume_instr: got %h want 33", if_instr); end checks++;
      if (fetch_count !== 32'd3) begin errors++; $display("FAIL stall_resume_count: got %0d want 3", fetch_count); end checks++;
   endtask

   task automatic test_redirect();
      stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0103;
      step();
      if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_valid: got %0b want 0", if_valid); end checks++;
      if (rom_addr !== 10'h040) begin errors++; $display("FAIL redir_rom_addr: got %h want 040", rom_addr); end checks++;
      if (if_pc !== 32'h8) begin errors++; $display("FAIL redir_pc_kept: got %h want 8", if_pc); end checks++;
      if (fetch_count !== 32'd3) begin errors++; $display("FAIL redir_count: got %0d want 3", fetch_count); end checks++;
      stall = 1'b0; redirect = 1'b0;
      step();
      if (if_pc !== 32'h100) begin errors++; $display("FAIL redir_target_pc: got %h want 100", if_pc); end checks++;
      if (if_instr !== 32'h1000_0040) begin errors++; $display("FAIL redir_target_instr: got %h want 10000040", if_instr); end checks++;
      if (if_valid !== 1'b1) begin errors++; $display("FAIL redir_target_valid: got %0b want 1", if_valid); end checks++;
   endtask

   task automatic test_wrap();
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
      step();
      redirect = 1'b0;
      if (rom_addr !== 10'h3FF) begin errors++; $display("FAIL wrap_alias_addr: got %h want 3ff", rom_addr); end checks++;
      step();
      if (if_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc: got %h want fffffffc", if_pc); end checks++;
      if (if_instr !== 32'h1000_03FF) begin errors++; $display("FAIL wrap_instr: got %h want 100003ff", if_instr); end checks++;
      if (rom_addr !== 10'h000) begin errors++; $display("FAIL wrap_next_addr: got %h want 0", rom_addr); end checks++;
   endtask

   task automatic test_halt();
      do_reset();
      repeat (5) step();
      if (halted !== 1'b0) begin errors++; $display("FAIL halt_early: got %0b want 0", halted); end checks++;
      step();
      if (if_instr !== 32'h0000_000C) begin errors++; $display("FAIL halt_instr: got %h want 0000000c", if_instr); end checks++;
      if (if_valid !== 1'b1) begin errors++; $display("FAIL halt_delivered: got %0b want 1", if_valid); end checks++;
      if (if_pc !== 32'h14) begin errors++; $display("FAIL halt_pc: got %h want 14", if_pc); end checks++;
      if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %0b want 1", halted); end checks++;
      if (rom_sel !== 1'b0) begin errors++; $display("FAIL halt_rom_sel: got %0b want 0", rom_sel); end checks++;
      if (rom_addr !== 10'd6) begin errors++; $display("FAIL halt_rom_addr: got %h want 6", rom_addr); end checks++;
      if (fetch_count !== 32'd6) begin errors++; $display("FAIL halt_count: got %0d want 6", fetch_count); end checks++;
      stall = 1'b1;
      step();
      if (if_valid !== 1'b1) begin errors++; $display("FAIL halt_stall_hold: got %0b want 1", if_valid); end checks++;
      stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0200;
      step();
      if (if_valid !== 1'b0) begin errors++; $display("FAIL halt_bubble: got %0b want 0", if_valid); end checks++;
      if (rom_addr !== 10'd6) begin errors++; $display("FAIL halt_redirect_ignored: got %h want 6", rom_addr); end checks++;
      if (halted !== 1'b1) begin errors++; $display("FAIL halt_sticky: got %0b want 1", halted); end checks++;
      redirect = 1'b0;
      step();
      if (fetch_count !== 32'd6) begin errors++; $display("FAIL halt_count_frozen: got %0d want 6", fetch_count); end checks++;
   endtask

   task automatic test_no_halt();
      do_reset();
      repeat (5) step();
      stall = 1'b1;
      step();
      if (halted !== 1'b0) begin errors++; $display("FAIL nohalt_stall: got %0b want 0", halted); end checks++;
      if (rom_sel !== 1'b1) begin errors++; $display("FAIL nohalt_stall_sel: got %0b want 1", rom_sel); end checks++;
      stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0300;
      step();
      if (halted !== 1'b0) begin errors++; $display("FAIL nohalt_redirect: got %0b want 0", halted); end checks++;
      if (rom_addr !== 10'h0C0) begin errors++; $display("FAIL nohalt_rom_addr: got %h want 0c0", rom_addr); end checks++;
      redirect = 1'b0;
      step();
      if (if_pc !== 32'h300) begin errors++; $display("FAIL nohalt_pc: got %h want 300", if_pc); end checks++;
      if (if_instr !== 32'h1000_00C0) begin errors++; $display("FAIL nohalt_instr: got %h want 100000c0", if_instr); end checks++;
      if (fetch_count !== 32'd6) begin errors++; $display("FAIL nohalt_count: got %0d want 6", fetch_count); end checks++;
   endtask

   task automatic test_reset_while_halted();
      do_reset();
      repeat (5) step();
      redirect = 1'b1; redirect_pc = 32'h0000_0200;
      step();
      redirect = 1'b0;
      repeat (32) step();
      if (halted !== 1'b1) begin errors++; $display("FAIL rh_halted: got %0b want 1", halted); end checks++;
      if (fetch_count !== 32'd37) begin errors++; $display("FAIL rh_count: got %0d want 37", fetch_count); end checks++;
      if (if_pc !== 32'h27C) begin errors++; $display("FAIL rh_pc: got %h want 27c", if_pc); end checks++;
      step();
      rst_n = 1'b0; stall = 1'b1; redirect = 1'b1;
      step();
      if (if_valid !== 1'b0) begin errors++; $display("FAIL rh_reset_valid: got %0b want 0", if_valid); end checks++;
      if (if_instr !== 32'h0) begin errors++; $display("FAIL rh_reset_instr: got %h want 0", if_instr); end checks++;
      if (if_pc !== 32'h0) begin errors++; $display("FAIL rh_reset_pc: got %h want 0", if_pc); end checks++;
      if (halted !== 1'b0) begin errors++; $display("FAIL rh_reset_halted: got %0b want 0", halted); end checks++;
      if (fetch_count !== 32'h0) begin errors++; $display("FAIL rh_reset_count: got %0d want 0", fetch_count); end checks++;
      if (rom_addr !== 10'h0) begin errors++; $display("FAIL rh_reset_addr: got %h want 0", rom_addr); end checks++;
      rst_n = 1'b1; stall = 1'b0; redirect = 1'b0;
      step();
      if (if_instr !== 32'h11) begin errors++; $display("FAIL rh_resume_instr: got %h want 11", if_instr); end checks++;
      if (if_valid !== 1'b1) begin errors++; $display("FAIL rh_resume_valid: got %0b want 1", if_valid); end checks++;
      if (fetch_count !== 32'd1) begin errors++; $display("FAIL rh_resume_count: got %0d want 1", fetch_count); end checks++;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) rom[i] = 32'h1000_0000 | 32'(i);
      rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33; rom[3] = 32'h44;
      rom[4] = 32'h55; rom[5] = 32'h0000_000C; rom[10'h09F] = 32'h0000_000C;
      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_wrap();
      test_halt();
      test_no_halt();
      test_reset_while_halted();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter HALT_INSTR, default 32'h0000_000C (syscall), instruction word that stops fetch.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port stall  input  1  downstream not accepting; hold PC and IF/ID outputs.
REQ-006 SHALL have port redirect  input  1  branch/jump taken; load redirect_pc, squash current fetch.
REQ-007 SHALL have port redirect_pc  input  32  redirect target; bits [1:0] ignored.
REQ-008 SHALL have port rom_addr  output  10  word address to instruction ROM, equal to pc[11:2].
REQ-009 SHALL have port rom_sel  output  1  ROM enable.
REQ-010 SHALL have port rom_data  input  32  instruction word from ROM, combinational from rom_addr/rom_sel.
REQ-011 SHALL have port if_pc  output  32  PC of the instruction in if_instr.
REQ-012 SHALL have port if_instr  output  32  registered instruction for decode.
REQ-013 SHALL have port if_valid  output  1  if_instr/if_pc hold a real instruction.
REQ-014 SHALL have port halted  output  1  fetch stopped after HALT_INSTR.
REQ-015 SHALL have port fetch_count  output  32  number of accepted fetches.

Function
REQ-016 SHALL hold a 32-bit pc register, pc[1:0] always 2'b00.
REQ-017 SHALL drive rom_sel = 1 only when state is RUN and rst_n is high; rom_addr = pc[11:2] always.
REQ-018 SHALL define an accepted fetch as a cycle with state RUN, stall=0, redirect=0.
REQ-019 On an accepted fetch: if_instr<=rom_data, if_pc<=pc, if_valid<=1, pc<=pc+4 (32-bit wrap, 0xFFFF_FFFC -> 0), fetch_count+1.
REQ-020 On redirect (RUN): pc<={redirect_pc[31:2],2'b00}, if_valid<=0, if_instr/if_pc unchanged; redirect overrides stall.
REQ-021 On stall without redirect: pc, if_instr, if_pc, if_valid unchanged; no count.
REQ-022 Fetch latency: instruction at pc appears on if_instr one cycle after the cycle rom_addr=pc[11:2] is accepted.
REQ-023 rom_addr SHALL wrap modulo 1024 words; pc above 0xFFC aliases into the ROM without error.
REQ-024 FSM states RUN, HALTED; RUN -> HALTED on an accepted fetch whose rom_data == HALT_INSTR; HALTED exits only via reset.
REQ-025 The halting instruction SHALL itself be delivered (if_valid=1) on the transition cycle.
REQ-026 In HALTED: pc frozen, rom_sel=0, halted=1; if_valid<=0 on the first non-stall cycle, held while stall=1; redirect ignored.
REQ-027 HALT_INSTR fetched in the same cycle as redirect or stall SHALL NOT halt (not accepted).
REQ-028 fetch_count SHALL saturate at 32'hFFFF_FFFF.

Reset
REQ-029 When rst_n=0 at a clock edge: pc<=RESET_PC, state<=RUN, if_valid<=0, if_instr<=0, if_pc<=0, halted<=0, fetch_count<=0.
REQ-030 Reset SHALL override stall, redirect and HALTED; reset mid-stall or mid-redirect discards pending work.
REQ-031 First accepted fetch SHALL be the first edge with rst_n=1, fetching RESET_PC.

Structure
REQ-032 Shared package mips_pkg SHALL hold ROM_AW=10, XLEN=32, default HALT_INSTR, and the fetch-state enum.
REQ-033 IF/ID output register (if_pc, if_instr, if_valid with hold/bubble control) SHALL be sub-module if_id_reg; PC, FSM and counter stay in if_stage.

Verification
REQ-034 Reset release, ROM words 0..3 = 0x11,0x22,0x33,0x44, no stall -> if_instr 0x11,0x22,0x33,0x44 on consecutive cycles, if_pc 0,4,8,C, fetch_count 4.
REQ-035 stall=1 for 3 cycles at pc=8 -> if_instr/if_pc frozen at word at 4/0x4, rom_addr held at 2, fetch_count unchanged.
REQ-036 redirect=1, redirect_pc=0x103 with stall=1 -> next cycle if_valid=0, pc=0x100, rom_addr=0x40; following cycle if_pc=0x100.
REQ-037 ROM word 5 = 0x0000000C -> if_instr=0x0000000C valid once, then halted=1, rom_sel=0, if_valid=0, pc stays 0x18; redirect ignored.
REQ-038 Same syscall at word 5 but redirect asserted when pc=0x14 -> no halt, fetch continues at redirect_pc.
REQ-039 rst_n=0 for one cycle while HALTED with fetch_count=37 -> all outputs reset values, fetch resumes at RESET_PC next cycle.
